riscv_dmem_arbiter: RTL and testbench

Two-requester arbiter for the single-port data memory of the RISC-V core. Port 0 is the core load/store unit; port 1 is a debug/loader master that preloads or inspects DMEM while the core runs. The block grants at most one access per cycle, routes the synchronous-read data back to the issuer, and supports a bounded locked burst for port 1. It sits between the core datapath and the DMEM macro, inside `riscv`.

---
 rtl/riscv_dmem_arbiter.sv | 150 +++++++++++++++
 tb/tb_riscv_dmem_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_dmem_arbiter.sv
// Two-port arbiter for the core data memory: port 0 = load/store unit, port 1 = debug/loader with locked bursts.
// Optional `DMEM_ARB_RR_EN selects round-robin arbitration in ARB; undefined gives fixed priority to port 0.
//
// state   | meaning
// --------+------------------------------------------------
// ST_ARB  | normal arbitration between both ports
// ST_LOCK | port 1 owns the memory until lock drops or burst limit
module riscv_dmem_arbiter #(
    parameter int REG_WIDTH       = 32,
    parameter int DMEM_ADDR_WIDTH = 10,
    parameter int MAX_BURST       = 8
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       m0_req_valid,
    output logic                       m0_req_ready,
    input  logic                       m0_req_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] m0_req_addr,
    input  logic [REG_WIDTH-1:0]       m0_req_wdata,
    input  logic [REG_WIDTH/8-1:0]     m0_req_be,
    output logic                       m0_rsp_valid,
    output logic [REG_WIDTH-1:0]       m0_rsp_rdata,

    input  logic                       m1_req_valid,
    output logic                       m1_req_ready,
    input  logic                       m1_req_we,
    input  logic [DMEM_ADDR_WIDTH-1:0] m1_req_addr,
    input  logic [REG_WIDTH-1:0]       m1_req_wdata,
    input  logic [REG_WIDTH/8-1:0]     m1_req_be,
    output logic                       m1_rsp_valid,
    output logic [REG_WIDTH-1:0]       m1_rsp_rdata,
    input  logic                       m1_lock,

    output logic                       mem_en,
    output logic                       mem_we,
    output logic [DMEM_ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]       mem_wdata,
    output logic [REG_WIDTH/8-1:0]     mem_be,
    input  logic [REG_WIDTH-1:0]       mem_rdata
);

    localparam logic [0:0] ST_ARB  = 1'b0;
    localparam logic [0:0] ST_LOCK = 1'b1;
    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    logic [0:0] state_q;
    logic [7:0] cnt_q;
    logic       tag_q;
    logic       rd_q;
    logic       gnt0;
    logic       gnt1;

`ifdef DMEM_ARB_RR_EN
    logic rr_q;  // 1 = port 1 preferred on the next simultaneous request

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_q <= 1'b0;
        end else if (gnt0 || gnt1) begin
            rr_q <= gnt0;
        end
    end
`endif

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == ST_LOCK) begin
            gnt1 = m1_req_valid;
        end else if (m0_req_valid && m1_req_valid) begin
`ifdef DMEM_ARB_RR_EN
            gnt0 = ~rr_q;
            gnt1 = rr_q;
`else
            gnt0 = 1'b1;
`endif
        end else begin
            gnt0 = m0_req_valid;
            gnt1 = m1_req_valid;
        end
    end

    assign m0_req_ready = gnt0;
    assign m1_req_ready = gnt1;

    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (gnt1) begin
            mem_we    = m1_req_we;
            mem_addr  = m1_req_addr;
            mem_wdata = m1_req_wdata;
            mem_be    = m1_req_be;
        end else if (gnt0) begin
            mem_we    = m0_req_we;
            mem_addr  = m0_req_addr;
            mem_wdata = m0_req_wdata;
            mem_be    = m0_req_be;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ARB;
            cnt_q   <= 8'd0;
            tag_q   <= 1'b0;
            rd_q    <= 1'b0;
        end else begin
            tag_q <= gnt1;
            rd_q  <= mem_en & ~mem_we;
            case (state_q)
                ST_ARB: begin
                    // A limit of one means the first grant already ends the burst.
                    if (gnt1 && m1_lock && (BURST_MAX > 8'd1)) begin
                        state_q <= ST_LOCK;
                        cnt_q   <= 8'd1;
                    end
                end
                ST_LOCK: begin
                    if (!m1_lock) begin
                        state_q <= ST_ARB;
                        cnt_q   <= 8'd0;
                    end else if (gnt1) begin
                        if (cnt_q + 8'd1 >= BURST_MAX) begin
                            state_q <= ST_ARB;
                            cnt_q   <= 8'd0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                end
                default: begin
                    state_q <= ST_ARB;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    // Read data is zeroed unless a read response is actually being returned on that port.
    assign m0_rsp_valid = rd_q & ~tag_q;
    assign m1_rsp_valid = rd_q &  tag_q;
    assign m0_rsp_rdata = m0_rsp_valid ? mem_rdata : '0;
    assign m1_rsp_rdata = m1_rsp_valid ? mem_rdata : '0;

endmodule

// File: tb/tb_riscv_dmem_arbiter.sv
// Directed bench for riscv_dmem_arbiter with a small byte-enabled synchronous memory model.
module tb_riscv_dmem_arbiter;

    logic        clk;
    logic        reset;
    logic        m0_req_valid, m0_req_ready, m0_req_we;
    logic [9:0]  m0_req_addr;
    logic [31:0] m0_req_wdata;
    logic [3:0]  m0_req_be;
    logic        m0_rsp_valid;
    logic [31:0] m0_rsp_rdata;
    logic        m1_req_valid, m1_req_ready, m1_req_we;
    logic [9:0]  m1_req_addr;
    logic [31:0] m1_req_wdata;
    logic [3:0]  m1_req_be;
    logic        m1_rsp_valid;
    logic [31:0] m1_rsp_rdata;
    logic        m1_lock;
    logic        mem_en, mem_we;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:1023];

    int n_tests = 0;
    int n_fail  = 0;

    riscv_dmem_arbiter #(
        .REG_WIDTH(32),
        .DMEM_ADDR_WIDTH(10),
        .MAX_BURST(4)
    ) dut (
        .clk(clk), .reset(reset),
        .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_req_we(m0_req_we),
        .m0_req_addr(m0_req_addr), .m0_req_wdata(m0_req_wdata), .m0_req_be(m0_req_be),
        .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
        .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_req_we(m1_req_we),
        .m1_req_addr(m1_req_addr), .m1_req_wdata(m1_req_wdata), .m1_req_be(m1_req_be),
        .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata), .m1_lock(m1_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_be(mem_be), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_addr];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        m0_req_valid = 1'b0; m0_req_we = 1'b0; m0_req_addr = '0; m0_req_wdata = '0; m0_req_be = '0;
        m1_req_valid = 1'b0; m1_req_we = 1'b0; m1_req_addr = '0; m1_req_wdata = '0; m1_req_be = '0;
        m1_lock = 1'b0;
    endtask

    task automatic m0_read(input logic [9:0] a);
        m0_req_valid = 1'b1; m0_req_we = 1'b0; m0_req_addr = a;
    endtask

    task automatic m1_read(input logic [9:0] a);
        m1_req_valid = 1'b1; m1_req_we = 1'b0; m1_req_addr = a;
    endtask

    task automatic m1_write(input logic [9:0] a, input logic [31:0] d, input logic [3:0] be);
        m1_req_valid = 1'b1; m1_req_we = 1'b1; m1_req_addr = a; m1_req_wdata = d; m1_req_be = be;
    endtask

    task automatic test_reset();
        idle();
        mem_rdata = 32'h0;
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        #4;
        n_tests++;
        if ({m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, mem_en, mem_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b required 000000",
                     {m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid, mem_en, mem_we});
        end
        n_tests++;
        if ({mem_addr, mem_wdata, mem_be, m0_rsp_rdata, m1_rsp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr %h wdata %h be %h r0 %h r1 %h required all 0",
                     mem_addr, mem_wdata, mem_be, m0_rsp_rdata, m1_rsp_rdata);
        end
        step();
    endtask

    task automatic preload();
        m1_write(10'd5, 32'hDEADBEEF, 4'hF); step();
        m1_write(10'd3, 32'hFFFFFFFF, 4'hF); step();
        m1_write(10'd1, 32'hA1A1A1A1, 4'hF); step();
        m1_write(10'd2, 32'hB2B2B2B2, 4'hF); step();
        idle(); step();
    endtask

    task automatic test_single_read();
        m0_read(10'd5);
        #4;
        n_tests++;
        if ({m0_req_ready, mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 1'b0, 10'd5}) begin
            n_fail++;
            $display("FAIL single_read_issue: ready %b en %b we %b addr %0d required 1 1 0 5",
                     m0_req_ready, mem_en, mem_we, mem_addr);
        end
        step();
        idle();
        #4;
        n_tests++;
        if ({m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
            n_fail++;
            $display("FAIL single_read_rsp: v0 %b data %h v1 %b required 1 deadbeef 0",
                     m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid);
        end
        step();
    endtask

    task automatic test_write_read();
        m1_write(10'd3, 32'h11223344, 4'b0101);
        #4;
        n_tests++;
        if ({m1_req_ready, mem_we, mem_be, mem_wdata} !== {1'b1, 1'b1, 4'b0101, 32'h11223344}) begin
            n_fail++;
            $display("FAIL write_issue: ready %b we %b be %b wdata %h required 1 1 0101 11223344",
                     m1_req_ready, mem_we, mem_be, mem_wdata);
        end
        step();
        m1_read(10'd3);
        #4;
        n_tests++;
        if ({m1_req_ready, m1_rsp_valid, m0_rsp_valid} !== 3'b100) begin
            n_fail++;
            $display("FAIL write_no_rsp: ready %b v1 %b v0 %b required 1 0 0",
                     m1_req_ready, m1_rsp_valid, m0_rsp_valid);
        end
        step();
        idle();
        #4;
        n_tests++;
        if ({m1_rsp_valid, m1_rsp_rdata, m0_rsp_valid} !== {1'b1, 32'hFF22FF44, 1'b0}) begin
            n_fail++;
            $display("FAIL write_read_rsp: v1 %b data %h v0 %b required 1 ff22ff44 0",
                     m1_rsp_valid, m1_rsp_rdata, m0_rsp_valid);
        end
        step();
    endtask

    task automatic test_contention();
        logic [7:0] exp_g0;
        logic [7:0] exp_g1;
`ifdef DMEM_ARB_RR_EN
        exp_g0 = 8'b0000_0101;
        exp_g1 = 8'b0000_1010;
`else
        exp_g0 = 8'b0000_1111;
        exp_g1 = 8'b0000_0000;
`endif
        for (int c = 0; c < 4; c++) begin
            m0_read(10'd10);
            m1_read(10'd20);
            #4;
            n_tests++;
            if ({m0_req_ready, m1_req_ready} !== {exp_g0[c], exp_g1[c]}) begin
                n_fail++;
                $display("FAIL contention_c%0d: ready0 %b ready1 %b required %b %b",
                         c, m0_req_ready, m1_req_ready, exp_g0[c], exp_g1[c]);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_lock();
        // {m0_valid, m1_valid, m1_lock, exp_ready0, exp_ready1}
        logic [4:0] vec [0:9];
        vec[0] = 5'b01101;
        vec[1] = 5'b11101;
        vec[2] = 5'b11101;
        vec[3] = 5'b11101;
        vec[4] = 5'b11110;
        vec[5] = 5'b01101;
        vec[6] = 5'b11101;
        vec[7] = 5'b10100;
        vec[8] = 5'b10000;
        vec[9] = 5'b10010;
        for (int c = 0; c < 10; c++) begin
            idle();
            if (vec[c][4]) m0_read(10'd7);
            if (vec[c][3]) m1_read(10'(c));
            m1_lock = vec[c][2];
            #4;
            n_tests++;
            if ({m0_req_ready, m1_req_ready} !== vec[c][1:0]) begin
                n_fail++;
                $display("FAIL lock_c%0d: ready0 %b ready1 %b required %b",
                         c, m0_req_ready, m1_req_ready, vec[c][1:0]);
            end
            step();
        end
        idle();
        step();
    endtask

    task automatic test_back_to_back();
        m0_read(10'd1);
        #4;
        n_tests++;
        if (m0_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_issue0: ready0 %b required 1", m0_req_ready);
        end
        step();
        idle();
        m1_read(10'd2);
        #4;
        n_tests++;
        if ({m1_req_ready, m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid} !== {1'b1, 1'b1, 32'hA1A1A1A1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_rsp_a1: ready1 %b v0 %b data %h v1 %b required 1 1 a1a1a1a1 0",
                     m1_req_ready, m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid);
        end
        step();
        idle();
        m0_read(10'd3);
        #4;
        n_tests++;
        if ({m0_req_ready, m1_rsp_valid, m1_rsp_rdata, m0_rsp_valid, m0_rsp_rdata}
                !== {1'b1, 1'b1, 32'hB2B2B2B2, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL b2b_rsp_b2: ready0 %b v1 %b data1 %h v0 %b data0 %h required 1 1 b2b2b2b2 0 0",
                     m0_req_ready, m1_rsp_valid, m1_rsp_rdata, m0_rsp_valid, m0_rsp_rdata);
        end
        step();
        idle();
        #4;
        n_tests++;
        if ({m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid, m1_rsp_rdata} !== {1'b1, 32'hFF22FF44, 1'b0, 32'h0}) begin
            n_fail++;
            $display("FAIL b2b_rsp_c3: v0 %b data0 %h v1 %b data1 %h required 1 ff22ff44 0 0",
                     m0_rsp_valid, m0_rsp_rdata, m1_rsp_valid, m1_rsp_rdata);
        end
        step();
    endtask

    task automatic test_reset_mid_read();
        // Enter LOCK first so the reset must also clear the burst state.
        m1_read(10'd9);
        m1_lock = 1'b1;
        step();
        idle();
        m1_lock = 1'b1;
        m0_read(10'd5);
        reset = 1'b1;
        #4;
        n_tests++;
        if (m0_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_blocks_m0: ready0 %b required 0", m0_req_ready);
        end
        step();
        // Reset now sampled; issue a port-0 read while reset is still high.
        reset = 1'b1;
        idle();
        m0_read(10'd5);
        #4;
        n_tests++;
        if (m0_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_issue: ready0 %b required 1", m0_req_ready);
        end
        step();
        reset = 1'b0;
        idle();
        #4;
        n_tests++;
        if ({m0_rsp_valid, m1_rsp_valid, m0_req_ready, m1_req_ready, mem_en, mem_we,
             mem_addr, mem_wdata, mem_be, m0_rsp_rdata, m1_rsp_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_rsp: v0 %b v1 %b en %b data0 %h required all 0",
                     m0_rsp_valid, m1_rsp_valid, mem_en, m0_rsp_rdata);
        end
        step();
        m0_read(10'd5);
        m1_read(10'd6);
        m1_lock = 1'b1;
        #4;
        n_tests++;
        if ({m0_req_ready, m1_req_ready} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_clears_lock: ready0 %b ready1 %b required 1 0",
                     m0_req_ready, m1_req_ready);
        end
        step();
        idle();
        step();
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        preload();
        test_single_read();
        test_write_read();
        test_contention();
        test_lock();
        test_back_to_back();
        test_reset_mid_read();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
